data_memory_arbiter: RTL and testbench

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

---
 rtl/data_memory_arbiter.sv | 90 +++++++++
 tb/tb_data_memory_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: port 0 (core) has fixed
// priority, port 1 (DMA/debug) is guaranteed service after max_wait denied cycles.
module data_memory_arbiter #(
    parameter int n_bit       = 31,
    parameter int memory_size = 2047,
    parameter int max_wait    = 4
) (
    input  logic             in_clk,
    input  logic             in_reset,
    input  logic             in_req0,
    input  logic             in_req1,
    input  logic             in_we0,
    input  logic             in_we1,
    input  logic [n_bit:0]   in_addr0,
    input  logic [n_bit:0]   in_addr1,
    input  logic [n_bit:0]   in_wdata0,
    input  logic [n_bit:0]   in_wdata1,
    output logic             out_gnt0,
    output logic             out_gnt1,
    output logic [n_bit:0]   out_rdata0,
    output logic [n_bit:0]   out_rdata1,
    output logic             out_valid0,
    output logic             out_valid1,
    output logic             out_mem_we,
    output logic [n_bit:0]   out_mem_addr,
    output logic [n_bit:0]   out_mem_write_data,
    input  logic [n_bit:0]   in_mem_read_data,
    output logic             out_err
);

    localparam int               cnt_w    = (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    localparam logic [cnt_w-1:0] wait_max = cnt_w'(max_wait);
    localparam logic [n_bit:0]   addr_max = (n_bit + 1)'(memory_size);

    logic [cnt_w-1:0] wait_cnt;
    logic             force1;
    logic             oor0;
    logic             oor1;

    always_comb begin
        force1             = in_req1 && (wait_cnt == wait_max);
        oor0               = in_addr0 > addr_max;
        oor1               = in_addr1 > addr_max;
        out_gnt0           = !in_reset && in_req0 && !force1;
        out_gnt1           = !in_reset && in_req1 && (!in_req0 || force1);
        out_mem_we         = 1'b0;
        out_mem_addr       = '0;
        out_mem_write_data = '0;
        // Out-of-range accesses still present their address, but never write.
        if (out_gnt0) begin
            out_mem_we         = in_we0 && !oor0;
            out_mem_addr       = in_addr0;
            out_mem_write_data = in_wdata0;
        end else if (out_gnt1) begin
            out_mem_we         = in_we1 && !oor1;
            out_mem_addr       = in_addr1;
            out_mem_write_data = in_wdata1;
        end
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            out_rdata0 <= '0;
            out_rdata1 <= '0;
            out_valid0 <= 1'b0;
            out_valid1 <= 1'b0;
            out_err    <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            out_valid0 <= out_gnt0;
            out_valid1 <= out_gnt1;
            if (out_gnt0 && !in_we0) begin
                out_rdata0 <= oor0 ? '0 : in_mem_read_data;
            end
            if (out_gnt1 && !in_we1) begin
                out_rdata1 <= oor1 ? '0 : in_mem_read_data;
            end
            if ((out_gnt0 && oor0) || (out_gnt1 && oor1)) begin
                out_err <= 1'b1;
            end
            // Starvation counter saturates; any port-1 grant restarts it.
            if (out_gnt1) begin
                wait_cnt <= '0;
            end else if (in_req1 && (wait_cnt < wait_max)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter: stimulus queues expected completions,
// a negedge monitor pops them on each valid pulse and checks the returned read data.
module tb_data_memory_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, valid0, valid1, mem_we, err;
    logic [31:0] rdata0, rdata1, mem_addr, mem_write_data, mem_read_data;

    typedef struct {
        string       name;
        logic [31:0] data;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        e0;
    exp_t        e1;
    logic [31:0] last0;
    logic [31:0] last1;
    int          checks;
    int          errors;
    logic [31:0] mem [0:2047];

    data_memory_arbiter #(
        .n_bit(31),
        .memory_size(2047),
        .max_wait(4)
    ) dut (
        .in_clk(clk),
        .in_reset(rst),
        .in_req0(req0),
        .in_req1(req1),
        .in_we0(we0),
        .in_we1(we1),
        .in_addr0(addr0),
        .in_addr1(addr1),
        .in_wdata0(wdata0),
        .in_wdata1(wdata1),
        .out_gnt0(gnt0),
        .out_gnt1(gnt1),
        .out_rdata0(rdata0),
        .out_rdata1(rdata1),
        .out_valid0(valid0),
        .out_valid1(valid1),
        .out_mem_we(mem_we),
        .out_mem_addr(mem_addr),
        .out_mem_write_data(mem_write_data),
        .in_mem_read_data(mem_read_data),
        .out_err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: distinct initial contents, garbage returned beyond the top address.
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = i ^ 32'hA5A5_0000;
    end
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[10:0]] <= mem_write_data;
    end
    assign mem_read_data = (mem_addr <= 32'd2047) ? mem[mem_addr[10:0]] : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string name, input logic g0, input logic g1, input logic we,
                           input logic [31:0] addr, input logic [31:0] wd);
        chk({name, "_gnt0"}, {31'd0, gnt0}, {31'd0, g0});
        chk({name, "_gnt1"}, {31'd0, gnt1}, {31'd0, g1});
        chk({name, "_mem_we"}, {31'd0, mem_we}, {31'd0, we});
        chk({name, "_mem_addr"}, mem_addr, addr);
        chk({name, "_mem_wdata"}, mem_write_data, wd);
    endtask

    // A write expects read data to hold its previous value.
    task automatic push(input string name, input int port, input logic rd, input logic [31:0] data);
        exp_t e;
        e.name = name;
        if (port == 0) begin
            if (rd) last0 = data;
            e.data = last0;
            q0.push_back(e);
        end else begin
            if (rd) last1 = data;
            e.data = last1;
            q1.push_back(e);
        end
    endtask

    task automatic drive0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        req0 = r; we0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic drive1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        req1 = r; we1 = w; addr1 = a; wdata1 = d;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (valid0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL valid0_unexpected: got 1 expected 0");
            end else begin
                e0 = q0.pop_front();
                chk({e0.name, "_rdata0"}, rdata0, e0.data);
            end
        end
        if (valid1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL valid1_unexpected: got 1 expected 0");
            end else begin
                e1 = q1.pop_front();
                chk({e1.name, "_rdata1"}, rdata1, e1.data);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        last0  = '0;
        last1  = '0;
        rst    = 1'b1;
        drive0(1'b1, 1'b1, 32'd5, 32'h1111);
        drive1(1'b1, 1'b0, 32'd6, 32'd0);
        #1;
        chk_bus("reset", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("reset_rdata0", rdata0, 32'd0);
        chk("reset_rdata1", rdata1, 32'd0);
        chk("reset_valid0", {31'd0, valid0}, 32'd0);
        chk("reset_valid1", {31'd0, valid1}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        cyc();
        drive0(1'b0, 1'b0, 32'd0, 32'd0);
        drive1(1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cyc();
            chk_bus($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            chk($sformatf("idle%0d_valid0", i), {31'd0, valid0}, 32'd0);
            chk($sformatf("idle%0d_valid1", i), {31'd0, valid1}, 32'd0);
        end

        // Write then back-to-back read on port 0.
        drive0(1'b1, 1'b1, 32'd5, 32'h0000_CAFE);
        #1;
        chk_bus("wr0", 1'b1, 1'b0, 1'b1, 32'd5, 32'h0000_CAFE);
        push("wr0", 0, 1'b0, 32'd0);
        cyc();
        drive0(1'b1, 1'b0, 32'd5, 32'd0);
        #1;
        chk_bus("rd0", 1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
        push("rd0", 0, 1'b1, 32'h0000_CAFE);
        cyc();
        drive0(1'b0, 1'b0, 32'd0, 32'd0);

        drive1(1'b1, 1'b1, 32'd6, 32'h0000_55AA);
        #1;
        chk_bus("wr1", 1'b0, 1'b1, 1'b1, 32'd6, 32'h0000_55AA);
        push("wr1", 1, 1'b0, 32'd0);
        cyc();

        // Both requesting: four port-0 grants, then port 1, repeating.
        drive0(1'b1, 1'b0, 32'd5, 32'd0);
        drive1(1'b1, 1'b0, 32'd6, 32'd0);
        for (int k = 0; k < 10; k++) begin
            #1;
            if (k % 5 == 4) begin
                chk_bus($sformatf("arb%0d", k), 1'b0, 1'b1, 1'b0, 32'd6, 32'd0);
                push($sformatf("arb%0d", k), 1, 1'b1, 32'h0000_55AA);
            end else begin
                chk_bus($sformatf("arb%0d", k), 1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
                push($sformatf("arb%0d", k), 0, 1'b1, 32'h0000_CAFE);
            end
            cyc();
        end
        drive0(1'b0, 1'b0, 32'd0, 32'd0);

        // Out-of-range read on port 1.
        drive1(1'b1, 1'b0, 32'd2048, 32'd0);
        #1;
        chk_bus("oor_rd1", 1'b0, 1'b1, 1'b0, 32'd2048, 32'd0);
        push("oor_rd1", 1, 1'b1, 32'd0);
        cyc();
        drive1(1'b0, 1'b0, 32'd0, 32'd0);
        chk("err_set", {31'd0, err}, 32'd1);
        for (int i = 0; i < 3; i++) cyc();
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Out-of-range write must not alias onto address 3000 mod 2048 = 952.
        drive1(1'b1, 1'b1, 32'd3000, 32'h0000_1234);
        #1;
        chk_bus("oor_wr1", 1'b0, 1'b1, 1'b0, 32'd3000, 32'h0000_1234);
        push("oor_wr1", 1, 1'b0, 32'd0);
        cyc();
        drive1(1'b0, 1'b0, 32'd0, 32'd0);
        cyc();
        drive0(1'b1, 1'b0, 32'd952, 32'd0);
        #1;
        chk_bus("rd952", 1'b1, 1'b0, 1'b0, 32'd952, 32'd0);
        push("rd952", 0, 1'b1, 32'hA5A5_03B8);
        cyc();
        drive0(1'b0, 1'b0, 32'd0, 32'd0);
        chk("err_after_wr", {31'd0, err}, 32'd1);
        cyc();
        cyc();

        // Reset mid-cycle during a granted read: the access is dropped.
        drive0(1'b1, 1'b0, 32'd5, 32'd0);
        #1;
        chk("pre_rst_gnt0", {31'd0, gnt0}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk_bus("rst_mid", 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("rst_mid_rdata0", rdata0, 32'd0);
        chk("rst_mid_rdata1", rdata1, 32'd0);
        chk("rst_mid_valid0", {31'd0, valid0}, 32'd0);
        chk("rst_mid_err", {31'd0, err}, 32'd0);
        last0 = '0;
        last1 = '0;
        cyc();
        drive0(1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("post_rst_rdata0", rdata0, 32'd0);
        chk("post_rst_err", {31'd0, err}, 32'd0);

        drive0(1'b1, 1'b0, 32'd5, 32'd0);
        #1;
        chk_bus("post_rst_rd0", 1'b1, 1'b0, 1'b0, 32'd5, 32'd0);
        push("post_rst_rd0", 0, 1'b1, 32'h0000_CAFE);
        cyc();
        drive0(1'b0, 1'b0, 32'd0, 32'd0);
        cyc();
        cyc();

        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
